// File: rtl/issue_dispatch_unit.sv
// Buffered issue stage: IF instruction queue, decode, ROB allocation, rename and RS/LSB dispatch.
// Optional feature macro ISSUE_CDB_BYPASS_EN captures a same-cycle CDB result into the operand payload.
module issue_dispatch_unit #(
  parameter int IQ_LOG  = 3,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic               inst_valid,
  input  logic [31:0]        inst_from_if,
  input  logic [31:0]        pc_from_if,
  output logic               iq_full,
  output logic [4:0]         rs1_to_reg,
  output logic [4:0]         rs2_to_reg,
  input  logic [31:0]        Vj_from_reg,
  input  logic               Rj_from_reg,
  input  logic [ROB_LOG-1:0] Qj_from_reg,
  input  logic [31:0]        Vk_from_reg,
  input  logic               Rk_from_reg,
  input  logic [ROB_LOG-1:0] Qk_from_reg,
  input  logic               rob_full,
  input  logic [ROB_LOG-1:0] rob_next,
  input  logic               rs_full,
  input  logic               lsb_full,
  input  logic               cdb_valid,
  input  logic [ROB_LOG-1:0] cdb_rob_id,
  input  logic [31:0]        cdb_value,
  output logic               rob_send_enable,
  output logic [OP_LOG-1:0]  rob_send_op,
  output logic [4:0]         rob_send_dest,
  output logic [31:0]        rob_send_pc,
  output logic               reg_send_enable,
  output logic [4:0]         reg_send_index,
  output logic [ROB_LOG-1:0] send_RobId,
  output logic               rs_send_enable,
  output logic               lsb_send_enable,
  output logic [OP_LOG-1:0]  send_op,
  output logic [31:0]        send_Vj,
  output logic               send_Rj,
  output logic [ROB_LOG-1:0] send_Qj,
  output logic [31:0]        send_Vk,
  output logic               send_Rk,
  output logic [ROB_LOG-1:0] send_Qk,
  output logic [31:0]        send_Imm,
  output logic [31:0]        send_CurPc
);
  localparam int IQ_DEPTH = 1 << IQ_LOG;

  // Loads and stores are numbered contiguously so memory ops are one range check.
  localparam logic [OP_LOG-1:0] OP_NOP = OP_LOG'(0),  OP_LUI = OP_LOG'(1),  OP_AUIPC = OP_LOG'(2),
    OP_JAL = OP_LOG'(3), OP_JALR = OP_LOG'(4), OP_BEQ = OP_LOG'(5), OP_BNE = OP_LOG'(6),
    OP_BLT = OP_LOG'(7), OP_BGE = OP_LOG'(8), OP_BLTU = OP_LOG'(9), OP_BGEU = OP_LOG'(10),
    OP_LB = OP_LOG'(11), OP_LH = OP_LOG'(12), OP_LW = OP_LOG'(13), OP_LBU = OP_LOG'(14),
    OP_LHU = OP_LOG'(15), OP_SB = OP_LOG'(16), OP_SH = OP_LOG'(17), OP_SW = OP_LOG'(18),
    OP_ADDI = OP_LOG'(19), OP_SLTI = OP_LOG'(20), OP_SLTIU = OP_LOG'(21), OP_XORI = OP_LOG'(22),
    OP_ORI = OP_LOG'(23), OP_ANDI = OP_LOG'(24), OP_SLLI = OP_LOG'(25), OP_SRLI = OP_LOG'(26),
    OP_SRAI = OP_LOG'(27), OP_ADD = OP_LOG'(28), OP_SUB = OP_LOG'(29), OP_SLL = OP_LOG'(30),
    OP_SLT = OP_LOG'(31), OP_SLTU = OP_LOG'(32), OP_XOR = OP_LOG'(33), OP_SRL = OP_LOG'(34),
    OP_SRA = OP_LOG'(35), OP_OR = OP_LOG'(36), OP_AND = OP_LOG'(37);

  logic [31:0]       inst_q [IQ_DEPTH];
  logic [31:0]       pc_q   [IQ_DEPTH];
  logic [IQ_LOG-1:0] head, tail;
  logic [IQ_LOG:0]   count;
  logic [31:0]       head_inst, head_pc, imm;
  logic [OP_LOG-1:0] op;
  logic              is_mem, is_store, is_branch, writes_rd, enq, dispatch, j_hit, k_hit;

  assign head_inst  = inst_q[head];
  assign head_pc    = pc_q[head];
  assign rs1_to_reg = head_inst[19:15];
  assign rs2_to_reg = head_inst[24:20];
  assign iq_full    = count[IQ_LOG];

  always_comb begin
    op  = OP_NOP;
    imm = '0;
    case (head_inst[6:0])
      7'b0110111: begin op = OP_LUI;   imm = {head_inst[31:12], 12'b0}; end
      7'b0010111: begin op = OP_AUIPC; imm = {head_inst[31:12], 12'b0}; end
      7'b1101111: begin
        op  = OP_JAL;
        imm = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20], head_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        op  = (head_inst[14:12] == 3'd0) ? OP_JALR : OP_NOP;
        imm = {{20{head_inst[31]}}, head_inst[31:20]};
      end
      7'b1100011: begin
        imm = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25], head_inst[11:8], 1'b0};
        case (head_inst[14:12])
          3'd0: op = OP_BEQ;  3'd1: op = OP_BNE;  3'd4: op = OP_BLT;
          3'd5: op = OP_BGE;  3'd6: op = OP_BLTU; 3'd7: op = OP_BGEU;
          default: ;
        endcase
      end
      7'b0000011: begin
        imm = {{20{head_inst[31]}}, head_inst[31:20]};
        case (head_inst[14:12])
          3'd0: op = OP_LB; 3'd1: op = OP_LH; 3'd2: op = OP_LW; 3'd4: op = OP_LBU; 3'd5: op = OP_LHU;
          default: ;
        endcase
      end
      7'b0100011: begin
        imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
        case (head_inst[14:12])
          3'd0: op = OP_SB; 3'd1: op = OP_SH; 3'd2: op = OP_SW;
          default: ;
        endcase
      end
      7'b0010011: begin
        imm = {{20{head_inst[31]}}, head_inst[31:20]};
        case (head_inst[14:12])
          3'd0: op = OP_ADDI; 3'd1: op = OP_SLLI; 3'd2: op = OP_SLTI; 3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI; 3'd5: op = head_inst[30] ? OP_SRAI : OP_SRLI;
          3'd6: op = OP_ORI;  default: op = OP_ANDI;
        endcase
      end
      7'b0110011: begin
        case (head_inst[14:12])
          3'd0: op = head_inst[30] ? OP_SUB : OP_ADD; 3'd1: op = OP_SLL; 3'd2: op = OP_SLT;
          3'd3: op = OP_SLTU; 3'd4: op = OP_XOR; 3'd5: op = head_inst[30] ? OP_SRA : OP_SRL;
          3'd6: op = OP_OR;   default: op = OP_AND;
        endcase
      end
      default: ;
    endcase
  end

  assign is_mem    = (op >= OP_LB) && (op <= OP_SW);
  assign is_store  = (op >= OP_SB) && (op <= OP_SW);
  assign is_branch = (op >= OP_BEQ) && (op <= OP_BGEU);
  assign writes_rd = (head_inst[11:7] != 5'd0) && !is_store && !is_branch;
  assign enq       = inst_valid && !iq_full && rdy && !flush;
  assign dispatch  = rdy && !flush && (count != '0) && !rob_full && (is_mem ? !lsb_full : !rs_full);

`ifdef ISSUE_CDB_BYPASS_EN
  assign j_hit = !Rj_from_reg && cdb_valid && (cdb_rob_id == Qj_from_reg);
  assign k_hit = !Rk_from_reg && cdb_valid && (cdb_rob_id == Qk_from_reg);
`else
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_rob_id, cdb_value};
  assign j_hit = 1'b0;
  assign k_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[tail] <= inst_from_if;
      pc_q[tail]   <= pc_from_if;
    end
  end

  // Flush wins over any same-cycle enqueue or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)      tail <= tail + 1'b1;
      if (dispatch) head <= head + 1'b1;
      case ({enq, dispatch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_send_enable <= 1'b0;
      reg_send_enable <= 1'b0;
      rs_send_enable  <= 1'b0;
      lsb_send_enable <= 1'b0;
      rob_send_op     <= '0;
      rob_send_dest   <= '0;
      rob_send_pc     <= '0;
      reg_send_index  <= '0;
      send_RobId      <= '0;
      send_op         <= '0;
      send_Vj         <= '0;
      send_Rj         <= 1'b0;
      send_Qj         <= '0;
      send_Vk         <= '0;
      send_Rk         <= 1'b0;
      send_Qk         <= '0;
      send_Imm        <= '0;
      send_CurPc      <= '0;
    end else begin
      rob_send_enable <= dispatch;
      reg_send_enable <= dispatch && writes_rd;
      rs_send_enable  <= dispatch && !is_mem;
      lsb_send_enable <= dispatch && is_mem;
      if (dispatch) begin
        rob_send_op    <= op;
        rob_send_dest  <= head_inst[11:7];
        rob_send_pc    <= head_pc;
        reg_send_index <= head_inst[11:7];
        send_RobId     <= rob_next;
        send_op        <= op;
        send_Vj        <= j_hit ? cdb_value : Vj_from_reg;
        send_Rj        <= Rj_from_reg || j_hit;
        send_Qj        <= Qj_from_reg;
        send_Vk        <= k_hit ? cdb_value : Vk_from_reg;
        send_Rk        <= Rk_from_reg || k_hit;
        send_Qk        <= Qk_from_reg;
        send_Imm       <= imm;
        send_CurPc     <= head_pc;
      end
    end
  end
endmodule
